// File: rtl/shift_seq_ctrl.sv
// -----------------------------------------------------------------------------
// shift_seq_ctrl
//
// Purpose
//   Command sequencer that sits directly upstream of an 8-bit barrel shifter.
//   One shift command is accepted over a valid/ready handshake. The operand is
//   then pushed through the shifter REP times: each cycle the shifter's
//   combinational output is written back into the accumulator, which drives
//   the shifter input again on the next cycle. The final word is returned over
//   a second valid/ready handshake. An abort input cuts the iteration short.
//
// Ports
//   clk          in   1      system clock, rising edge
//   rst_n        in   1      synchronous reset, active-low
//   cmd_valid    in   1      command present
//   cmd_ready    out  1      command can be accepted (IDLE only)
//   cmd_data     in   WIDTH  initial operand
//   cmd_shamt    in   SHW    shift amount applied on every iteration
//   cmd_lr       in   1      1 = left, 0 = right
//   cmd_al       in   1      1 = arithmetic, 0 = logical (right shifts only)
//   cmd_rep      in   REPW   number of iterations (0 = pass operand through)
//   cmd_abort    in   1      stop iterating; only looked at in RUN
//   sh_din       out  WIDTH  barrel shifter data input (accumulator)
//   sh_shamt     out  SHW    barrel shifter shift amount (latched)
//   sh_lr        out  1      barrel shifter direction (latched)
//   sh_al        out  1      barrel shifter arithmetic/logical (latched)
//   sh_dout      in   WIDTH  barrel shifter result (combinational return)
//   res_valid    out  1      result present
//   res_ready    in   1      consumer takes the result
//   res_data     out  WIDTH  final operand
//   res_aborted  out  1      result was cut short by cmd_abort
//   busy         out  1      controller is not idle
// -----------------------------------------------------------------------------
module shift_seq_ctrl #(
   parameter int WIDTH = 8,
   parameter int SHW   = 3,
   parameter int REPW  = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [WIDTH-1:0] cmd_data,
   input  logic [SHW-1:0]   cmd_shamt,
   input  logic             cmd_lr,
   input  logic             cmd_al,
   input  logic [REPW-1:0]  cmd_rep,
   input  logic             cmd_abort,
   output logic [WIDTH-1:0] sh_din,
   output logic [SHW-1:0]   sh_shamt,
   output logic             sh_lr,
   output logic             sh_al,
   input  logic [WIDTH-1:0] sh_dout,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [WIDTH-1:0] res_data,
   output logic             res_aborted,
   output logic             busy
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [WIDTH-1:0]  acc_q,     acc_d;
   logic [REPW-1:0]   cnt_q,     cnt_d;
   logic [SHW-1:0]    shamt_q,   shamt_d;
   logic              lr_q,      lr_d;
   logic              al_q,      al_d;
   logic              aborted_q, aborted_d;

   // The iteration that consumes the final count value: leaving RUN happens on
   // the same edge that stores the last shifter result. The <= 1 form also
   // keeps a corrupted zero count from wrapping to 15.
   logic last_iter;
   assign last_iter = (cnt_q <= REPW'(1));

   // --------------------------------------------------------------------------
   // State and datapath registers
   // --------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         acc_q     <= '0;
         cnt_q     <= '0;
         shamt_q   <= '0;
         lr_q      <= 1'b0;
         al_q      <= 1'b0;
         aborted_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         acc_q     <= acc_d;
         cnt_q     <= cnt_d;
         shamt_q   <= shamt_d;
         lr_q      <= lr_d;
         al_q      <= al_d;
         aborted_q <= aborted_d;
      end
   end

   // --------------------------------------------------------------------------
   // Next-state logic
   // --------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: begin
            if (cmd_valid) begin
               state_d = (cmd_rep != '0) ? S_RUN : S_DONE;
            end
         end
         S_RUN: begin
            // Abort wins over a normal final iteration.
            if (cmd_abort || last_iter) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            // cmd_valid is not looked at here, so there is always one IDLE
            // cycle between handing off a result and accepting new work.
            if (res_ready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // --------------------------------------------------------------------------
   // Datapath next values
   // --------------------------------------------------------------------------
   always_comb begin
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      shamt_d   = shamt_q;
      lr_d      = lr_q;
      al_d      = al_q;
      aborted_d = aborted_q;
      unique case (state_q)
         S_IDLE: begin
            if (cmd_valid) begin
               acc_d     = cmd_data;
               cnt_d     = cmd_rep;
               shamt_d   = cmd_shamt;
               lr_d      = cmd_lr;
               al_d      = cmd_al;
               aborted_d = 1'b0;
            end
         end
         S_RUN: begin
            if (cmd_abort) begin
               // Keep the last completed iteration; the in-flight one is dropped.
               aborted_d = 1'b1;
            end else begin
               acc_d = sh_dout;
               if (cnt_q != '0) begin
                  cnt_d = cnt_q - REPW'(1);
               end
            end
         end
         default: begin
            // DONE: everything holds until the result is taken.
         end
      endcase
   end

   // --------------------------------------------------------------------------
   // Outputs: all driven from registers, never straight from cmd_*
   // --------------------------------------------------------------------------
   always_comb begin
      cmd_ready   = (state_q == S_IDLE);
      res_valid   = (state_q == S_DONE);
      busy        = (state_q != S_IDLE);
      res_data    = acc_q;
      res_aborted = aborted_q;
      sh_din      = acc_q;
      sh_shamt    = shamt_q;
      sh_lr       = lr_q;
      sh_al       = al_q;
   end

   // --------------------------------------------------------------------------
   // Invariants
   // --------------------------------------------------------------------------
   // A RUN cycle always has at least one iteration left to perform.
   a_run_cnt_nonzero : assert property (
      @(posedge clk) disable iff (!rst_n)
      (state_q == S_RUN) |-> (cnt_q != '0));

   // A result that is not taken stays exactly where it is.
   a_done_hold : assert property (
      @(posedge clk) disable iff (!rst_n)
      (state_q == S_DONE && !res_ready) |=>
         (state_q == S_DONE && $stable(acc_q) && $stable(aborted_q)));

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_shift_seq_ctrl
//
// Directed bench for shift_seq_ctrl. The barrel shifter that the controller
// drives is modelled here combinationally. Every expected value is a
// hand-computed constant.
// -----------------------------------------------------------------------------
module tb_shift_seq_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [7:0] cmd_data;
   logic [2:0] cmd_shamt;
   logic       cmd_lr;
   logic       cmd_al;
   logic [3:0] cmd_rep;
   logic       cmd_abort;
   logic [7:0] sh_din;
   logic [2:0] sh_shamt;
   logic       sh_lr;
   logic       sh_al;
   logic [7:0] sh_dout;
   logic       res_valid;
   logic       res_ready;
   logic [7:0] res_data;
   logic       res_aborted;
   logic       busy;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   shift_seq_ctrl dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_data    (cmd_data),
      .cmd_shamt   (cmd_shamt),
      .cmd_lr      (cmd_lr),
      .cmd_al      (cmd_al),
      .cmd_rep     (cmd_rep),
      .cmd_abort   (cmd_abort),
      .sh_din      (sh_din),
      .sh_shamt    (sh_shamt),
      .sh_lr       (sh_lr),
      .sh_al       (sh_al),
      .sh_dout     (sh_dout),
      .res_valid   (res_valid),
      .res_ready   (res_ready),
      .res_data    (res_data),
      .res_aborted (res_aborted),
      .busy        (busy)
   );

   // Barrel shifter model: left ignores AL, right is arithmetic when AL=1.
   always_comb begin
      if (sh_lr)
         sh_dout = sh_din << sh_shamt;
      else if (sh_al)
         sh_dout = 8'($signed(sh_din) >>> sh_shamt);
      else
         sh_dout = sh_din >> sh_shamt;
   end

   // Advance one clock; sampling and driving happen 1 time unit after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one command for one accept edge, then wait (bounded) for the
   // result. edges counts clock edges from and including the accept edge;
   // -1 means the result never appeared.
   task automatic send_cmd(input logic [7:0] d, input logic [2:0] sh,
                           input logic lr, input logic al, input logic [3:0] rep,
                           output int edges);
      cmd_data  = d;
      cmd_shamt = sh;
      cmd_lr    = lr;
      cmd_al    = al;
      cmd_rep   = rep;
      cmd_valid = 1'b1;
      tick();
      cmd_valid = 1'b0;
      edges = 1;
      while (!res_valid && edges < 40) begin
         tick();
         edges++;
      end
      if (!res_valid) edges = -1;
   endtask

   task automatic pop_result();
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tick();
      tick();
      checks++;
      if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready got %b want 1", cmd_ready); end
      checks++;
      if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid got %b want 0", res_valid); end
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
      checks++;
      if (sh_din !== 8'h00) begin errors++; $display("FAIL reset_sh_din got %h want 00", sh_din); end
      checks++;
      if ({sh_shamt, sh_lr, sh_al, res_aborted} !== 6'b0) begin
         errors++;
         $display("FAIL reset_regs got shamt=%0d lr=%b al=%b ab=%b want all 0", sh_shamt, sh_lr, sh_al, res_aborted);
      end
      rst_n = 1'b1;
      tick();
      $display("txn reset cmd_ready=%b res_valid=%b busy=%b", cmd_ready, res_valid, busy);
   endtask

   task automatic test_left();
      int edges;
      // Check the shifter pins one cycle into RUN, before the loop finishes.
      cmd_data = 8'h96; cmd_shamt = 3'd1; cmd_lr = 1'b1; cmd_al = 1'b0; cmd_rep = 4'd3;
      cmd_valid = 1'b1;
      tick();
      cmd_valid = 1'b0;
      checks++;
      if (sh_din !== 8'h96 || sh_shamt !== 3'd1 || sh_lr !== 1'b1 || busy !== 1'b1 || cmd_ready !== 1'b0) begin
         errors++;
         $display("FAIL left_run_pins got din=%h shamt=%0d lr=%b busy=%b rdy=%b want 96 1 1 1 0",
                  sh_din, sh_shamt, sh_lr, busy, cmd_ready);
      end
      edges = 1;
      while (!res_valid && edges < 40) begin tick(); edges++; end
      checks++;
      if (edges !== 4) begin errors++; $display("FAIL left_latency got %0d want 4", edges); end
      checks++;
      if (res_data !== 8'hB0) begin errors++; $display("FAIL left_data got %h want b0", res_data); end
      checks++;
      if (res_aborted !== 1'b0) begin errors++; $display("FAIL left_aborted got %b want 0", res_aborted); end
      $display("txn left data=96 shamt=1 rep=3 result=%h aborted=%b edges=%0d", res_data, res_aborted, edges);
      pop_result();
      checks++;
      if (cmd_ready !== 1'b1 || res_valid !== 1'b0) begin
         errors++;
         $display("FAIL left_pop got rdy=%b vld=%b want 1 0", cmd_ready, res_valid);
      end
   endtask

   task automatic test_arith_right();
      int edges;
      send_cmd(8'h96, 3'd2, 1'b0, 1'b1, 4'd2, edges);
      checks++;
      if (edges !== 3) begin errors++; $display("FAIL asr_latency got %0d want 3", edges); end
      checks++;
      if (res_data !== 8'hF9) begin errors++; $display("FAIL asr_data got %h want f9", res_data); end
      $display("txn asr data=96 shamt=2 rep=2 result=%h edges=%0d", res_data, edges);
      pop_result();
   endtask

   task automatic test_logic_right();
      int edges;
      send_cmd(8'h80, 3'd7, 1'b0, 1'b0, 4'd1, edges);
      checks++;
      if (edges !== 2) begin errors++; $display("FAIL lsr_latency got %0d want 2", edges); end
      checks++;
      if (res_data !== 8'h01) begin errors++; $display("FAIL lsr_data got %h want 01", res_data); end
      $display("txn lsr data=80 shamt=7 rep=1 result=%h edges=%0d", res_data, edges);
      pop_result();
      // Left with AL=1 is still a plain left shift: 0xC1 << 2 = 0x04.
      send_cmd(8'hC1, 3'd2, 1'b1, 1'b1, 4'd1, edges);
      checks++;
      if (res_data !== 8'h04) begin errors++; $display("FAIL left_al_data got %h want 04", res_data); end
      $display("txn left_al data=c1 shamt=2 rep=1 result=%h edges=%0d", res_data, edges);
      pop_result();
   endtask

   task automatic test_rep_zero();
      int edges;
      send_cmd(8'h5A, 3'd3, 1'b1, 1'b0, 4'd0, edges);
      checks++;
      if (edges !== 1) begin errors++; $display("FAIL rep0_latency got %0d want 1", edges); end
      checks++;
      if (res_data !== 8'h5A) begin errors++; $display("FAIL rep0_data got %h want 5a", res_data); end
      $display("txn rep0 data=5a result=%h edges=%0d", res_data, edges);
      pop_result();
      send_cmd(8'h5A, 3'd0, 1'b0, 1'b1, 4'd5, edges);
      checks++;
      if (edges !== 6) begin errors++; $display("FAIL shamt0_latency got %0d want 6", edges); end
      checks++;
      if (res_data !== 8'h5A) begin errors++; $display("FAIL shamt0_data got %h want 5a", res_data); end
      $display("txn shamt0 data=5a rep=5 result=%h edges=%0d", res_data, edges);
      pop_result();
   endtask

   task automatic test_backpressure();
      int edges;
      int bad;
      send_cmd(8'h3C, 3'd1, 1'b0, 1'b0, 4'd1, edges);  // 0x3C >> 1 = 0x1E
      bad = 0;
      for (int i = 0; i < 5; i++) begin
         // A competing command during DONE must be ignored.
         if (i == 2) begin
            cmd_data = 8'hFF; cmd_rep = 4'd0; cmd_valid = 1'b1;
         end
         tick();
         cmd_valid = 1'b0;
         if (res_valid !== 1'b1 || res_data !== 8'h1E || cmd_ready !== 1'b0) bad++;
      end
      checks++;
      if (bad !== 0) begin
         errors++;
         $display("FAIL backpressure_hold got vld=%b data=%h rdy=%b bad_cycles=%0d want 1 1e 0 0",
                  res_valid, res_data, cmd_ready, bad);
      end
      $display("txn backpressure result=%h held 5 cycles", res_data);
      pop_result();
      // Stays idle afterwards: the DONE-time pulse left nothing behind.
      tick();
      checks++;
      if (res_valid !== 1'b0 || cmd_ready !== 1'b1) begin
         errors++;
         $display("FAIL backpressure_release got vld=%b rdy=%b want 0 1", res_valid, cmd_ready);
      end
   endtask

   task automatic test_abort();
      // Abort ignored while idle.
      cmd_abort = 1'b1;
      tick();
      cmd_abort = 1'b0;
      cmd_data = 8'h01; cmd_shamt = 3'd1; cmd_lr = 1'b1; cmd_al = 1'b0; cmd_rep = 4'd15;
      cmd_valid = 1'b1;
      tick();               // accept
      cmd_valid = 1'b0;
      tick();               // RUN cycle 1: acc = 02
      tick();               // RUN cycle 2: acc = 04
      cmd_abort = 1'b1;
      tick();               // RUN cycle 3: aborted, acc held
      cmd_abort = 1'b0;
      checks++;
      if (res_valid !== 1'b1) begin errors++; $display("FAIL abort_valid got %b want 1", res_valid); end
      checks++;
      if (res_data !== 8'h04) begin errors++; $display("FAIL abort_data got %h want 04", res_data); end
      checks++;
      if (res_aborted !== 1'b1) begin errors++; $display("FAIL abort_flag got %b want 1", res_aborted); end
      $display("txn abort data=01 rep=15 result=%h aborted=%b", res_data, res_aborted);
      pop_result();
   endtask

   task automatic test_reset_mid_run();
      cmd_data = 8'h01; cmd_shamt = 3'd1; cmd_lr = 1'b1; cmd_al = 1'b0; cmd_rep = 4'd15;
      cmd_valid = 1'b1;
      tick();
      cmd_valid = 1'b0;
      tick();
      tick();
      rst_n = 1'b0;
      tick();
      checks++;
      if (cmd_ready !== 1'b1 || res_valid !== 1'b0 || busy !== 1'b0 || sh_din !== 8'h00 || res_aborted !== 1'b0) begin
         errors++;
         $display("FAIL midrun_reset got rdy=%b vld=%b busy=%b din=%h ab=%b want 1 0 0 00 0",
                  cmd_ready, res_valid, busy, sh_din, res_aborted);
      end
      rst_n = 1'b1;
      tick();
      tick();
      checks++;
      if (res_valid !== 1'b0 || cmd_ready !== 1'b1) begin
         errors++;
         $display("FAIL midrun_no_result got vld=%b rdy=%b want 0 1", res_valid, cmd_ready);
      end
      $display("txn reset_mid_run cmd_ready=%b res_valid=%b sh_din=%h", cmd_ready, res_valid, sh_din);
   endtask

   initial begin
      rst_n     = 1'b0;
      cmd_valid = 1'b0;
      cmd_data  = '0;
      cmd_shamt = '0;
      cmd_lr    = 1'b0;
      cmd_al    = 1'b0;
      cmd_rep   = '0;
      cmd_abort = 1'b0;
      res_ready = 1'b0;
      #1;
      test_reset();
      test_left();
      test_arith_right();
      test_logic_right();
      test_rep_zero();
      test_backpressure();
      test_abort();
      test_reset_mid_run();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
